// File: rtl/div_mn_pkg.sv
// Shared types for the fractional divider: run state, config record, reset defaults and legality rule.
package div_mn_pkg;
  localparam int PKG_DIV_W   = 8;
  localparam int PKG_FRAC_W  = 8;
  localparam int PKG_DEF_DIV = 8;
  localparam int PKG_DEF_NUM = 7;
  localparam int PKG_DEF_DEN = 10;
  localparam int PKG_DEF_MODE = 0;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [PKG_DIV_W-1:0]  div;
    logic [PKG_FRAC_W-1:0] num;
    logic [PKG_FRAC_W-1:0] den;
    logic                  mode;
  } cfg_t;

  function automatic logic cfg_legal(input cfg_t c);
    return (c.div >= PKG_DIV_W'(2)) && (c.den != '0) && (c.num < c.den);
  endfunction
endpackage

// File: rtl/frac_period_seq.sv
// Decides long/short for the period about to start and flags the last period of a frame.
// Outputs are combinational on the upcoming period; state advances on each start strobe.
module frac_period_seq
  import div_mn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  input  logic first,
  input  cfg_t cfg,
  output logic long_nxt,
  output logic last_nxt
);
  localparam int FW = PKG_FRAC_W;

  logic [FW-1:0] idx, idx_n;
  logic [FW:0]   acc, acc_n, acc_base, sum, den_x;

  always_comb begin
    den_x    = {1'b0, cfg.den};
    idx_n    = first ? '0 : idx + 1'b1;
    acc_base = first ? '0 : acc;
    sum      = acc_base + {1'b0, cfg.num};
    acc_n    = (sum >= den_x) ? sum - den_x : sum;
    // grouped: the last R periods of the frame are long
    if (cfg.mode) long_nxt = (sum >= den_x);
    else          long_nxt = (idx_n >= (cfg.den - cfg.num));
    last_nxt = (idx_n == cfg.den - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
      acc <= '0;
    end else if (start) begin
      idx <= idx_n;
      acc <= acc_n;
    end
  end
endmodule

// File: rtl/div_frac_mn.sv
// Fractional clock divider: frames of N sub-periods of D or D+1 cycles, R of them long.
// Config widths follow the package; a config accepted while running waits in a shadow until a frame boundary.
module div_frac_mn
  import div_mn_pkg::*;
#(
  parameter int DIV_W    = PKG_DIV_W,
  parameter int FRAC_W   = PKG_FRAC_W,
  parameter int DEF_DIV  = PKG_DEF_DIV,
  parameter int DEF_NUM  = PKG_DEF_NUM,
  parameter int DEF_DEN  = PKG_DEF_DEN,
  parameter int DEF_MODE = PKG_DEF_MODE
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  input  logic              cfg_mode,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              tick,
  output logic              frame_start,
  output logic              long_per,
  output logic              busy
);
  localparam int CW = PKG_DIV_W + 1;
  localparam cfg_t DEF_CFG = '{div: PKG_DIV_W'(DEF_DIV), num: PKG_FRAC_W'(DEF_NUM),
                               den: PKG_FRAC_W'(DEF_DEN), mode: 1'(DEF_MODE)};

  state_t        state;
  cfg_t          active, shadow, cfg_in, nxt_cfg, use_cfg;
  logic          pend, accept, acc_ok, period_end, frame_end, first, start;
  logic          last_per, long_nxt, last_nxt;
  logic [CW-1:0] cnt, plen, cnt_n, plen_n;

  always_comb begin
    cfg_in     = '{div: cfg_div, num: cfg_num, den: cfg_den, mode: cfg_mode};
    accept     = cfg_valid & cfg_ready;
    acc_ok     = accept & cfg_legal(cfg_in);
    // a config accepted on a frame's last cycle bypasses the shadow straight into the next frame
    nxt_cfg    = acc_ok ? cfg_in : (pend ? shadow : active);
    period_end = (state == RUN) && (cnt == plen - 1'b1);
    frame_end  = period_end && last_per;
    first      = en && ((state == IDLE) || frame_end);
    start      = en && ((state == IDLE) || period_end);
    use_cfg    = first ? nxt_cfg : active;
    plen_n     = start ? ({1'b0, use_cfg.div} + CW'(long_nxt)) : plen;
    cnt_n      = start ? '0 : cnt + 1'b1;
  end

  frac_period_seq u_seq (
    .clk      (clk_in),
    .rst      (rst),
    .clear    (~en),
    .start    (start),
    .first    (first),
    .cfg      (use_cfg),
    .long_nxt (long_nxt),
    .last_nxt (last_nxt)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      active      <= DEF_CFG;
      shadow      <= DEF_CFG;
      pend        <= 1'b0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
      cnt         <= '0;
      plen        <= '0;
      last_per    <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      frame_start <= 1'b0;
      long_per    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cfg_err <= accept & ~cfg_legal(cfg_in);
      if (first || !en) begin
        active    <= nxt_cfg;
        pend      <= 1'b0;
        cfg_ready <= 1'b1;
      end else if (acc_ok) begin
        shadow    <= cfg_in;
        pend      <= 1'b1;
        cfg_ready <= 1'b0;
      end
      if (en) begin
        state       <= RUN;
        busy        <= 1'b1;
        cnt         <= cnt_n;
        plen        <= plen_n;
        clk_out     <= (cnt_n < (plen_n >> 1));
        tick        <= start;
        frame_start <= first;
        if (start) begin
          long_per <= long_nxt;
          last_per <= last_nxt;
        end
      end else begin
        state       <= IDLE;
        busy        <= 1'b0;
        cnt         <= '0;
        plen        <= '0;
        clk_out     <= 1'b0;
        tick        <= 1'b0;
        frame_start <= 1'b0;
        long_per    <= 1'b0;
        last_per    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_frac_mn.sv
// Bench for div_frac_mn: frame-level reference model feeds an expected-output queue, a monitor compares every cycle.
module tb_div_frac_mn;
  logic       clk_in = 1'b0;
  logic       rst, en, cfg_valid, cfg_mode;
  logic [7:0] cfg_div, cfg_num, cfg_den;
  logic       cfg_ready, cfg_err, clk_out, tick, frame_start, long_per, busy;

  always #5 clk_in = ~clk_in;

  div_frac_mn dut (
    .clk_in(clk_in), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick), .frame_start(frame_start),
    .long_per(long_per), .busy(busy)
  );

  typedef struct packed {logic co, tk, fs, lp, by, rd, er;} out_t;
  typedef struct {int d, r, n, mode;} mcfg_t;

  out_t  sb[$];
  out_t  fq[$];
  out_t  mon_e, mon_a;
  int    total = 0, bad = 0, cyc_no = 0;
  mcfg_t m_act, m_sh;
  bit    m_pend, m_ready, m_run;
  localparam mcfg_t DEFC = '{8, 7, 10, 0};

  function automatic bit legal(input mcfg_t c);
    return c.d >= 2 && c.n >= 1 && c.r < c.n;
  endfunction

  // Expand one frame into per-cycle outputs from the ratio rules directly.
  task automatic build_frame(input mcfg_t c);
    for (int i = 0; i < c.n; i++) begin
      bit lng;
      int p;
      if (c.mode != 0) lng = (((i + 1) * c.r) / c.n - (i * c.r) / c.n) != 0;
      else             lng = (i >= c.n - c.r);
      p = c.d + (lng ? 1 : 0);
      for (int k = 0; k < p; k++) begin
        out_t o = '0;
        o.co = (k < p / 2);
        o.tk = (k == 0);
        o.fs = (k == 0) && (i == 0);
        o.lp = lng;
        fq.push_back(o);
      end
    end
  endtask

  // Expected outputs after the coming edge, given the inputs now on the pins.
  task automatic model_step();
    out_t  e = '0;
    mcfg_t inc;
    bit    hs, ok;
    if (rst) begin
      m_act = DEFC; m_pend = 0; m_ready = 1; m_run = 0;
      fq.delete();
    end else begin
      inc = '{int'(cfg_div), int'(cfg_num), int'(cfg_den), int'(cfg_mode)};
      hs  = cfg_valid && m_ready;
      ok  = hs && legal(inc);
      if (!en || !m_run || fq.size() == 0) begin
        if (ok) m_act = inc;
        else if (m_pend) m_act = m_sh;
        m_pend = 0; m_ready = 1;
        fq.delete();
        if (en) build_frame(m_act);
      end else if (ok) begin
        m_sh = inc; m_pend = 1; m_ready = 0;
      end
      m_run = en;
      if (en) e = fq.pop_front();
      e.er = hs && !ok;
    end
    e.rd = m_ready;
    e.by = m_run;
    sb.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk_in);
    cyc_no++;
  endtask

  task automatic offer(input int d, input int r, input int n, input int mode);
    cfg_valid = 1'b1;
    cfg_div = 8'(d); cfg_num = 8'(r); cfg_den = 8'(n); cfg_mode = 1'(mode);
    cyc();
    cfg_valid = 1'b0;
  endtask

  always @(posedge clk_in) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_a = '{clk_out, tick, frame_start, long_per, busy, cfg_ready, cfg_err};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got co=%b tk=%b fs=%b lp=%b busy=%b rdy=%b err=%b want co=%b tk=%b fs=%b lp=%b busy=%b rdy=%b err=%b",
                 cyc_no, mon_a.co, mon_a.tk, mon_a.fs, mon_a.lp, mon_a.by, mon_a.rd, mon_a.er,
                 mon_e.co, mon_e.tk, mon_e.fs, mon_e.lp, mon_e.by, mon_e.rd, mon_e.er);
      end
    end
  end

  initial begin
    rst = 1; en = 0; cfg_valid = 0; cfg_div = 0; cfg_num = 0; cfg_den = 0; cfg_mode = 0;
    m_act = DEFC; m_sh = DEFC; m_pend = 0; m_ready = 1; m_run = 0;
    repeat (3) cyc();
    rst = 0;
    repeat (2) cyc();
    en = 1;
    repeat (200) cyc();
    offer(8, 7, 10, 1);
    repeat (300) cyc();
    offer(3, 1, 2, 0);
    repeat (120) cyc();
    offer(1, 1, 4, 0);
    repeat (5) cyc();
    offer(5, 4, 4, 0);
    repeat (20) cyc();
    offer(4, 0, 1, 0);
    repeat (30) cyc();
    en = 0;
    repeat (3) cyc();
    en = 1;
    repeat (20) cyc();
    offer(255, 1, 2, 1);
    repeat (600) cyc();
    offer(6, 2, 5, 1);
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0;
    repeat (200) cyc();
    repeat (4000) begin
      rst       = ($urandom_range(0, 999) == 0);
      en        = ($urandom_range(0, 99) != 0);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_div   = 8'($urandom_range(1, 7));
      cfg_num   = 8'($urandom_range(0, 7));
      cfg_den   = 8'($urandom_range(0, 7));
      cfg_mode  = 1'($urandom_range(0, 1));
      cyc();
    end
    rst = 0; cfg_valid = 0;
    @(posedge clk_in);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
